// File: rtl/matrix_scan_driver.sv
// Row-scan driver for LED dot matrices: multi-frame sprite store, per-row dwell/blank,
// and frame-synchronous alternation between a primary and an alternate sprite.
module matrix_scan_driver #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int FRAMES         = 4,
  parameter int DWELL          = 2,
  parameter int BLANK          = 1,
  parameter int ANIM_FRAMES    = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  localparam int RW = $clog2(ROWS),
  localparam int FW = $clog2(FRAMES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            scan_en_i,
  input  logic            load_valid_i,
  output logic            load_ready_o,
  input  logic [FW-1:0]   load_frame_i,
  input  logic [RW-1:0]   load_row_i,
  input  logic [COLS-1:0] load_data_i,
  input  logic [FW-1:0]   sel_frame_i,
  input  logic            anim_en_i,
  input  logic [FW-1:0]   alt_frame_i,
  output logic [ROWS-1:0] row_sel_o,
  output logic [COLS-1:0] col_data_o,
  output logic            frame_start_o,
  output logic            anim_phase_o
);

  localparam int CW       = $clog2(DWELL + BLANK + 1);
  localparam int AW       = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int BLANK_LD = (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ROW_ACTIVE_LOW}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW, S_BLANK} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
  logic            phase_q, phase_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [COLS-1:0] word_q, word_d;
  logic [COLS-1:0] store_q [FRAMES][ROWS];

  logic            wr_ok, rd_ok, last_row, advance;
  logic [FW-1:0]   fetch_frame;
  logic [COLS-1:0] rd_word;

  // Non-power-of-two stores need explicit range guards; aliasing would corrupt other words.
  if (FRAMES == (1 << FW)) begin : g_fr_full
    assign rd_ok = 1'b1;
    if (ROWS == (1 << RW)) begin : g_rw_full
      assign wr_ok = 1'b1;
    end else begin : g_rw_part
      assign wr_ok = (load_row_i < RW'(ROWS));
    end
  end else begin : g_fr_part
    assign rd_ok = (fetch_frame < FW'(FRAMES));
    if (ROWS == (1 << RW)) begin : g_rw_full
      assign wr_ok = (load_frame_i < FW'(FRAMES));
    end else begin : g_rw_part
      assign wr_ok = (load_frame_i < FW'(FRAMES)) && (load_row_i < RW'(ROWS));
    end
  end

  // The sprite choice is only sampled on row 0 so a frame is never torn.
  assign fetch_frame = (row_q == '0) ? ((anim_en_i && phase_q) ? alt_frame_i : sel_frame_i)
                                     : shadow_q;
  assign rd_word     = rd_ok ? store_q[fetch_frame][row_q] : '0;
  assign last_row    = (row_q == RW'(ROWS - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    anim_cnt_d = anim_cnt_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        row_d   = '0;
      end
      S_FETCH: begin
        word_d   = rd_word;
        shadow_d = fetch_frame;
        cnt_d    = CW'(DWELL - 1);
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (BLANK > 0) begin
          cnt_d   = CW'(BLANK_LD);
          state_d = S_BLANK;
        end else begin
          advance = 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      state_d = S_FETCH;
      row_d   = last_row ? '0 : row_q + RW'(1);
      if (last_row) begin
        if (anim_cnt_q == AW'(ANIM_FRAMES - 1)) begin
          anim_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          anim_cnt_d = anim_cnt_q + AW'(1);
        end
      end
    end
    // scan_en low aborts from any state; animation progress is frozen, not lost.
    if (!scan_en_i) begin
      state_d    = S_IDLE;
      row_d      = '0;
      anim_cnt_d = anim_cnt_q;
      phase_d    = phase_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      anim_cnt_q <= '0;
      phase_q    <= 1'b0;
      shadow_q   <= '0;
      word_q     <= '0;
      for (int f = 0; f < FRAMES; f++)
        for (int r = 0; r < ROWS; r++)
          store_q[f][r] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      anim_cnt_q <= anim_cnt_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
      if (load_valid_i && wr_ok) store_q[load_frame_i][load_row_i] <= load_data_i;
    end
  end

  always_comb begin
    row_sel_o  = ROW_OFF;
    col_data_o = '0;
    if (state_q == S_SHOW) begin
      row_sel_o  = ROW_OFF ^ (ROWS'(1) << (RW'(ROWS - 1) - row_q));
      col_data_o = word_q;
    end
  end

  assign frame_start_o = (state_q == S_FETCH) && (row_q == '0);
  assign anim_phase_o  = phase_q;
  assign load_ready_o  = ~rst_i;

endmodule
